image_write_stream: RTL and testbench

Receives the two-pixels-per-cycle RGB stream produced by the image reader/processing path (`data_write` plus `DATA_R0..DATA_B1`) and buffers one full frame. Once the frame is complete, it replays the frame as a 24-bit BMP byte stream over a valid/ready byte interface. It is the sink end of the pixel stream, and feeds a file dumper in simulation or a byte transport on chip. It restores BMP bottom-up row order and BGR byte order, and inserts row padding.

---
 rtl/image_write_stream.sv | 181 ++++++++++++++++++
 tb/tb_image_write_stream.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/image_write_stream.sv
// Frame buffer sink: captures a two-pixels-per-cycle RGB stream, then replays it as a 24-bit BMP byte stream.
// Define BMP_HEADER_EN to prepend the 54-byte BMP header; otherwise only raw padded pixel rows are emitted.
module image_write_stream #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       data_write,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  output logic       busy,
  output logic       drop_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done
);
  localparam int PAD    = (4 - ((3 * WIDTH) % 4)) % 4;
  localparam int STRIDE = 3 * WIDTH + PAD;
  localparam int IMG    = STRIDE * HEIGHT;
  localparam int PAIRS  = WIDTH * HEIGHT / 2;
`ifdef BMP_HEADER_EN
  localparam int HDR = 54;
`else
  localparam int HDR = 0;
`endif
  localparam int TOTAL = HDR + IMG;
  localparam int AW = $clog2(IMG);
  localparam int PW = $clog2(PAIRS + 1);
  localparam int SW = $clog2(TOTAL + 1);
  localparam int CW = $clog2(STRIDE + 1);
  localparam logic [AW-1:0] BASE0 = AW'((HEIGHT - 1) * STRIDE);

  typedef enum logic [1:0] {ST_CAPTURE, ST_HEADER, ST_PIXEL, ST_DONE} st_t;

  st_t           st_q, st_d;
  logic [PW-1:0] pairs_q, pairs_d;
  logic [AW-1:0] c3_q, c3_d, base_q, base_d;
  logic [1:0]    prime_q, prime_d;
  logic [SW-1:0] ld_q, ld_d;
  logic [CW-1:0] lcol_q, lcol_d;
  logic          ov_q, ov_d, derr_q, derr_d;
  logic [7:0]    od_q, od_d;
  logic          wr_en, load, is_hdr;
  logic [7:0]    nbyte, hbyte;
  logic [AW-1:0] waddr, paddr;
  logic [7:0]    mem [IMG];

`ifdef BMP_HEADER_EN
  // Byte i of the header lives at bits [8i+7:8i]; fields are little-endian.
  localparam logic [431:0] HDR_V = {
    32'd0, 32'd0, 32'd0, 32'd0, 32'(IMG), 32'd0, 16'd24, 16'd1,
    32'(HEIGHT), 32'(WIDTH), 32'd40, 32'd54, 32'd0, 32'(54 + IMG), 16'h4D42};
  logic [5:0] hidx;
  assign hidx   = ld_q[5:0];
  assign is_hdr = (ld_q < SW'(HDR));
  assign hbyte  = HDR_V[{hidx, 3'b000} +: 8];
`else
  assign is_hdr = 1'b0;
  assign hbyte  = 8'h00;
`endif

  assign waddr = base_q + c3_q;
  assign paddr = AW'(ld_q - SW'(HDR));

  always_comb begin
    nbyte = 8'h00;
    if (is_hdr)                       nbyte = hbyte;
    else if (lcol_q < CW'(3 * WIDTH)) nbyte = mem[paddr];
  end

  // Output register reloads on the priming slot and on every transfer that still has bytes behind it.
  assign load = prime_q[1] || (ov_q && out_ready && (ld_q != SW'(TOTAL)));

  always_comb begin
    st_d    = st_q;
    pairs_d = pairs_q;
    c3_d    = c3_q;
    base_d  = base_q;
    prime_d = {prime_q[0], 1'b0};
    ld_d    = ld_q;
    lcol_d  = lcol_q;
    ov_d    = ov_q;
    od_d    = od_q;
    derr_d  = derr_q | (data_write && busy);
    wr_en   = 1'b0;
    case (st_q)
      ST_CAPTURE: if (data_write) begin
        wr_en = 1'b1;
        if (pairs_q == PW'(PAIRS - 1)) begin
`ifdef BMP_HEADER_EN
          st_d = ST_HEADER;
`else
          st_d = ST_PIXEL;
`endif
          prime_d[0] = 1'b1;
          pairs_d    = '0;
          c3_d       = '0;
          base_d     = BASE0;
        end else begin
          pairs_d = pairs_q + PW'(1);
          if (c3_q == AW'(3 * (WIDTH - 2))) begin
            c3_d   = '0;
            base_d = base_q - AW'(STRIDE);
          end else begin
            c3_d = c3_q + AW'(6);
          end
        end
      end
      ST_HEADER, ST_PIXEL:
        if (ov_q && out_ready && (ld_q == SW'(TOTAL))) begin
          ov_d = 1'b0;
          st_d = ST_DONE;
        end
      ST_DONE: begin
        st_d   = ST_CAPTURE;
        ld_d   = '0;
        lcol_d = '0;
      end
      default: st_d = ST_CAPTURE;
    endcase
    if (load) begin
      ov_d = 1'b1;
      od_d = nbyte;
      ld_d = ld_q + SW'(1);
      if (!is_hdr) begin
        st_d   = ST_PIXEL;
        lcol_d = (lcol_q == CW'(STRIDE - 1)) ? '0 : lcol_q + CW'(1);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      st_q    <= ST_CAPTURE;
      pairs_q <= '0;
      c3_q    <= '0;
      base_q  <= BASE0;
      prime_q <= '0;
      ld_q    <= '0;
      lcol_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= 8'h00;
      derr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      pairs_q <= pairs_d;
      c3_q    <= c3_d;
      base_q  <= base_d;
      prime_q <= prime_d;
      ld_q    <= ld_d;
      lcol_q  <= lcol_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      derr_q  <= derr_d;
    end
  end

  // Pixel pair lands in BGR order; pad bytes are never written and are masked to zero on read.
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[waddr]          <= DATA_B0;
      mem[waddr + AW'(1)] <= DATA_G0;
      mem[waddr + AW'(2)] <= DATA_R0;
      mem[waddr + AW'(3)] <= DATA_B1;
      mem[waddr + AW'(4)] <= DATA_G1;
      mem[waddr + AW'(5)] <= DATA_R1;
    end
  end

  assign busy       = (st_q != ST_CAPTURE);
  assign frame_done = (st_q == ST_DONE);
  assign drop_err   = derr_q;
  assign out_valid  = ov_q;
  assign out_data   = od_q;
endmodule

// File: tb/tb_image_write_stream.sv
// Directed bench: 2x2 frame streams (free-running, stalled, dropped strobe, mid-send reset) and a 4x2 latency check.
module tb_image_write_stream;
`ifdef BMP_HEADER_EN
  localparam int HDR = 54;
`else
  localparam int HDR = 0;
`endif
  localparam int TOT_A = HDR + 16;
  localparam int TOT_B = HDR + 24;

  logic HCLK = 1'b0, HRESET = 1'b0;
  logic data_write = 1'b0, out_ready = 1'b1;
  logic [7:0] r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic busy, drop_err, out_valid, frame_done;
  logic [7:0] out_data;

  logic dw_b = 1'b0;
  logic [7:0] r0b = 0, g0b = 0, b0b = 0, r1b = 0, g1b = 0, b1b = 0;
  logic busy_b, derr_b, ov_b, fd_b;
  logic [7:0] od_b;

  int n_chk = 0, n_fail = 0;

  logic [7:0] hdr_c [54] = '{
    8'h42, 8'h4D, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
    8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h18, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] pix_c [16] = '{8'd9, 8'd8, 8'd7, 8'd12, 8'd11, 8'd10, 8'd0, 8'd0,
                            8'd3, 8'd2, 8'd1, 8'd6, 8'd5, 8'd4, 8'd0, 8'd0};
  logic [7:0] exp_b [TOT_A];

  image_write_stream #(.WIDTH(2), .HEIGHT(2)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .data_write(data_write),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .busy(busy), .drop_err(drop_err), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done));

  image_write_stream #(.WIDTH(4), .HEIGHT(2)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .data_write(dw_b),
    .DATA_R0(r0b), .DATA_G0(g0b), .DATA_B0(b0b), .DATA_R1(r1b), .DATA_G1(g1b), .DATA_B1(b1b),
    .busy(busy_b), .drop_err(derr_b), .out_data(od_b), .out_valid(ov_b),
    .out_ready(1'b1), .frame_done(fd_b));

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic build_exp(input bit ff);
    for (int i = 0; i < HDR; i++) exp_b[i] = hdr_c[i];
    for (int i = 0; i < 16; i++)
      exp_b[HDR + i] = ff ? ((i % 8 >= 6) ? 8'h00 : 8'hFF) : pix_c[i];
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
  endtask

  // Two pairs: row 0 = (1,2,3),(4,5,6); row 1 = (7,8,9),(10,11,12); or all 0xFF.
  task automatic send_a(input bit ff);
    chk("busy_capture", 32'(busy), 32'd0);
    for (int p = 0; p < 2; p++) begin
      data_write = 1'b1;
      r0 = ff ? 8'hFF : 8'(p * 6 + 1); g0 = ff ? 8'hFF : 8'(p * 6 + 2);
      b0 = ff ? 8'hFF : 8'(p * 6 + 3); r1 = ff ? 8'hFF : 8'(p * 6 + 4);
      g1 = ff ? 8'hFF : 8'(p * 6 + 5); b1 = ff ? 8'hFF : 8'(p * 6 + 6);
      tick();
    end
    data_write = 1'b0;
    chk("busy_after_last", 32'(busy), 32'd1);
  endtask

  task automatic run_stream(input bit toggle, input bit poke, input int stop);
    int k = 0;
    int first = -1;
    bit seen = 0, stalled = 0, poked = 0;
    logic [7:0] hold = 8'h00;
    for (int n = 0; n < 600; n++) begin
      data_write = 1'b0;
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(hold));
      end
      if (out_valid && first < 0) begin
        first = n;
        chk("first_valid_lat", 32'(n), 32'd2);
      end
      if (frame_done) begin
        seen = 1;
        chk("done_valid_low", 32'(out_valid), 32'd0);
        chk("byte_count", 32'(k), 32'(TOT_A));
        break;
      end
      if (stop > 0 && k >= stop) break;
      out_ready = toggle ? (n % 3 == 0) : 1'b1;
      if (poke && !poked && k == HDR + 2) begin
        data_write = 1'b1;
        {r0, g0, b0, r1, g1, b1} = {6{8'hEE}};
        poked = 1;
      end
      if (out_valid && out_ready) begin
        if (k < TOT_A) chk("stream_byte", 32'(out_data), 32'(exp_b[k]));
        else chk("overrun", 32'(k), 32'(TOT_A));
        k++;
      end
      stalled = out_valid && !out_ready;
      hold = out_data;
      tick();
    end
    data_write = 1'b0;
    out_ready = 1'b1;
    if (!seen && stop == 0) chk("done_timeout", 32'd0, 32'd1);
    if (seen) begin
      tick();
      chk("done_one_cycle", 32'(frame_done), 32'd0);
      chk("busy_released", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int cyc, k;
    #3 HRESET = 1'b1;
    #1 chk_reset_outs();
    tick(); tick();
    HRESET = 1'b0;
    tick();

    // Free-running sink
    build_exp(1'b0);
    send_a(1'b0);
    run_stream(1'b0, 1'b0, 0);
    chk("no_drop_yet", 32'(drop_err), 32'd0);

    // Back-pressured sink
    send_a(1'b0);
    run_stream(1'b1, 1'b0, 0);

    // Strobe during replay is dropped and flagged
    send_a(1'b0);
    run_stream(1'b0, 1'b1, 0);
    chk("drop_err_set", 32'(drop_err), 32'd1);
    tick(); tick();
    chk("drop_err_sticky", 32'(drop_err), 32'd1);

    // Reset in the middle of a send
    send_a(1'b0);
    run_stream(1'b0, 1'b0, 10);
    HRESET = 1'b1;
    #1 chk_reset_outs();
    tick();
    chk_reset_outs();
    HRESET = 1'b0;
    tick();
    build_exp(1'b1);
    send_a(1'b1);
    run_stream(1'b0, 1'b0, 0);

    // 4x2 frame: no padding, end-to-end latency from first strobe
    cyc = 0; k = 0;
    for (int p = 0; p < 4; p++) begin
      dw_b = 1'b1;
      r0b = 8'(p * 6 + 1); g0b = 8'(p * 6 + 2); b0b = 8'(p * 6 + 3);
      r1b = 8'(p * 6 + 4); g1b = 8'(p * 6 + 5); b1b = 8'(p * 6 + 6);
      tick(); cyc++;
    end
    dw_b = 1'b0;
    while (!fd_b && cyc < 400) begin
      if (ov_b) begin
        if (HDR > 0 && k == 2) chk("b_filesize", 32'(od_b), 32'd78);
        if (k == HDR) chk("b_first_pixel", 32'(od_b), 32'd15);
        if (k == HDR + 23) chk("b_last_pixel", 32'(od_b), 32'd10);
        k++;
      end
      tick(); cyc++;
    end
    chk("b_done_cycle", 32'(cyc), 32'(4 + 2 + HDR + 24));
    chk("b_byte_count", 32'(k), 32'(TOT_B));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
